// File: rtl/dir_router.sv
// Directional channel router: one read (src) and one write (dst) per core instruction,
// stalling the core via clk_en until the selected channel handshakes complete.
// Ports: clk, reset (sync, active-low); src/dst select codes; in_data/in_valid/in_ready
// inbound channels; out_data/out_valid/out_ready outbound channels; clk_en core advance;
// dir_src_data word read for the core; dir_dst_data word written by the core.
// Optional feature macro: DIR_ROUTER_ANY_LAST_EN enables the ANY and LAST select codes.
module dir_router #(
   parameter int WIDTH = 11,
   parameter int PORTS = 4,
   parameter int SEL_W = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [SEL_W-1:0]       src,
   input  logic [SEL_W-1:0]       dst,
   input  logic [PORTS*WIDTH-1:0] in_data,
   input  logic [PORTS-1:0]       in_valid,
   output logic [PORTS-1:0]       in_ready,
   output logic [PORTS*WIDTH-1:0] out_data,
   output logic [PORTS-1:0]       out_valid,
   input  logic [PORTS-1:0]       out_ready,
   output logic                   clk_en,
   output logic [WIDTH-1:0]       dir_src_data,
   input  logic [WIDTH-1:0]       dir_dst_data
);

   localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam logic [SEL_W-1:0] CODE_ANY = SEL_W'(PORTS);
   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_WRITE = 1'b1;

   logic                   state_q, state_d;
   logic [WIDTH-1:0]       hold_q, hold_d;
   logic [PORTS-1:0]       ov_q, ov_d;
   logic [PORTS*WIDTH-1:0] od_q, od_d;

   logic                   rd_sel, rd_none, rd_ok;
   logic [IW-1:0]          rd_ch;
   logic [WIDTH-1:0]       rd_word;
   logic [PORTS-1:0]       wr_mask;
   logic                   wr_xfer, is_idle;

`ifdef DIR_ROUTER_ANY_LAST_EN
   localparam logic [SEL_W-1:0] CODE_LAST = SEL_W'(PORTS + 1);
   logic [IW-1:0]          last_idx_q, last_idx_d;
   logic                   last_vld_q, last_vld_d;
   logic                   any_q, any_d;
   logic                   rd_any, wr_any;
   logic [IW-1:0]          wr_win;
`endif

   assign is_idle = (state_q == ST_IDLE);

   // Read select decode; rd_sel = a channel is selected, rd_none = no channel activity.
   // An ANY read with nothing valid leaves both low, which stalls.
   always_comb begin
      rd_sel  = 1'b0;
      rd_none = 1'b0;
      rd_ch   = '0;
`ifdef DIR_ROUTER_ANY_LAST_EN
      rd_any  = 1'b0;
`endif
      if (src < CODE_ANY) begin
         rd_sel = 1'b1;
         rd_ch  = src[IW-1:0];
      end
`ifdef DIR_ROUTER_ANY_LAST_EN
      else if (src == CODE_ANY) begin
         rd_any = 1'b1;
         for (int i = PORTS - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
               rd_sel = 1'b1;
               rd_ch  = IW'(i);
            end
         end
      end else if (src == CODE_LAST && last_vld_q) begin
         rd_sel = 1'b1;
         rd_ch  = last_idx_q;
      end
`endif
      else begin
         rd_none = 1'b1;
      end
   end

   // Write target decode; an empty mask means no write.
   always_comb begin
      wr_mask = '0;
`ifdef DIR_ROUTER_ANY_LAST_EN
      wr_any  = 1'b0;
`endif
      if (dst < CODE_ANY) begin
         wr_mask[dst[IW-1:0]] = 1'b1;
      end
`ifdef DIR_ROUTER_ANY_LAST_EN
      else if (dst == CODE_ANY) begin
         wr_mask = '1;
         wr_any  = 1'b1;
      end else if (dst == CODE_LAST && last_vld_q) begin
         wr_mask[last_idx_q] = 1'b1;
      end
`endif
   end

`ifdef DIR_ROUTER_ANY_LAST_EN
   // Lowest-index ready channel wins a broadcast write.
   always_comb begin
      wr_win = '0;
      for (int i = PORTS - 1; i >= 0; i--) begin
         if (ov_q[i] && out_ready[i]) wr_win = IW'(i);
      end
   end
`endif

   assign rd_ok   = rd_none | (rd_sel & in_valid[rd_ch]);
   assign rd_word = rd_sel ? in_data[rd_ch*WIDTH +: WIDTH] : '0;
   assign wr_xfer = |(ov_q & out_ready);

   always_comb begin
      in_ready = '0;
      if (reset && is_idle && rd_sel) in_ready[rd_ch] = in_valid[rd_ch];
   end

   assign clk_en       = reset & (is_idle ? (rd_ok & ~|wr_mask) : wr_xfer);
   assign dir_src_data = is_idle ? rd_word : hold_q;
   assign out_valid    = ov_q;
   assign out_data     = od_q;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      ov_d    = ov_q;
      od_d    = od_q;
`ifdef DIR_ROUTER_ANY_LAST_EN
      last_idx_d = last_idx_q;
      last_vld_d = last_vld_q;
      any_d      = any_q;
`endif
      if (is_idle) begin
         if (rd_ok && |wr_mask) begin
            state_d = ST_WRITE;
            hold_d  = rd_word;
            ov_d    = wr_mask;
            for (int i = 0; i < PORTS; i++) begin
               if (wr_mask[i]) od_d[i*WIDTH +: WIDTH] = dir_dst_data;
            end
`ifdef DIR_ROUTER_ANY_LAST_EN
            any_d = wr_any;
`endif
         end
`ifdef DIR_ROUTER_ANY_LAST_EN
         if (rd_any && rd_sel && in_valid[rd_ch]) begin
            last_idx_d = rd_ch;
            last_vld_d = 1'b1;
         end
`endif
      end else if (wr_xfer) begin
         state_d = ST_IDLE;
         ov_d    = '0;
`ifdef DIR_ROUTER_ANY_LAST_EN
         // Write happens after the read, so it overrides a same-instruction ANY read.
         if (any_q) begin
            last_idx_d = wr_win;
            last_vld_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         ov_q    <= '0;
         od_q    <= '0;
`ifdef DIR_ROUTER_ANY_LAST_EN
         last_idx_q <= '0;
         last_vld_q <= 1'b0;
         any_q      <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
`ifdef DIR_ROUTER_ANY_LAST_EN
         last_idx_q <= last_idx_d;
         last_vld_q <= last_vld_d;
         any_q      <= any_d;
`endif
      end
   end

endmodule

// File: tb/tb_dir_router.sv
// Self-checking bench for dir_router: directed scenarios plus a
// scoreboarded random stream of reads and writes.
module tb_dir_router;
   localparam int W = 11;
   localparam int P = 4;
   localparam int S = 3;
   localparam logic [S-1:0] NONE = 3'd7;
   localparam logic [S-1:0] ANY  = 3'd4;
   localparam logic [S-1:0] LAST = 3'd5;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [S-1:0] src = NONE;
   logic [S-1:0] dst = NONE;
   logic [P*W-1:0] in_data = '0;
   logic [P-1:0] in_valid = '0;
   logic [P-1:0] in_ready;
   logic [P*W-1:0] out_data;
   logic [P-1:0] out_valid;
   logic [P-1:0] out_ready = '0;
   logic         clk_en;
   logic [W-1:0] dir_src_data;
   logic [W-1:0] dir_dst_data = '0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int           ch;
      logic [W-1:0] d;
   } exp_t;
   exp_t sb[$];

   dir_router #(.WIDTH(W), .PORTS(P), .SEL_W(S)) dut (
      .clk(clk), .reset(reset), .src(src), .dst(dst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .clk_en(clk_en), .dir_src_data(dir_src_data),
      .dir_dst_data(dir_dst_data)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] od(int i);
      return out_data[i*W +: W];
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      src = 3'd0;
      in_valid = '1;
      in_data = {P{11'd3}};
      tick();
      checks++;
      if (out_valid !== 4'b0) begin
         errors++; $display("FAIL rst_ov got %b want 0000", out_valid);
      end
      checks++;
      if (out_data !== '0) begin
         errors++; $display("FAIL rst_od got %h want 0", out_data);
      end
      checks++;
      if (clk_en !== 1'b0) begin
         errors++; $display("FAIL rst_clken got %b want 0", clk_en);
      end
      checks++;
      if (in_ready !== 4'b0) begin
         errors++; $display("FAIL rst_ir got %b want 0000", in_ready);
      end
      reset = 1'b1;
      in_valid = '0;
      src = NONE;
      tick();
   endtask

   task automatic test_read;
      src = 3'd0;
      dst = NONE;
      in_data[0 +: W] = 11'd5;
      in_valid = 4'b0001;
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         errors++; $display("FAIL rd_ir got %b want 0001", in_ready);
      end
      checks++;
      if (dir_src_data !== 11'd5) begin
         errors++; $display("FAIL rd_data got %0d want 5", dir_src_data);
      end
      checks++;
      if (clk_en !== 1'b1) begin
         errors++; $display("FAIL rd_clken got %b want 1", clk_en);
      end
      in_valid = '0;
      #1;
      checks++;
      if (clk_en !== 1'b0 || in_ready !== 4'b0) begin
         errors++; $display("FAIL rd_stall got %b/%b want 0/0000", clk_en, in_ready);
      end
      checks++;
      if (dir_src_data !== 11'd5) begin
         errors++; $display("FAIL rd_comb got %0d want 5", dir_src_data);
      end
      tick();
      src = NONE;
   endtask

   task automatic test_write;
      src = NONE;
      dst = 3'd1;
      dir_dst_data = 11'(-7);
      out_ready = '0;
      #1;
      checks++;
      if (clk_en !== 1'b0) begin
         errors++; $display("FAIL wr_issue got %b want 0", clk_en);
      end
      tick();
      dst = NONE;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) out_ready = 4'b0010;
         #1;
         checks++;
         if (out_valid !== 4'b0010) begin
            errors++; $display("FAIL wr_ov%0d got %b want 0010", k, out_valid);
         end
         checks++;
         if (od(1) !== 11'(-7)) begin
            errors++; $display("FAIL wr_od%0d got %0d want -7", k, $signed(od(1)));
         end
         checks++;
         if (clk_en !== (k == 3)) begin
            errors++; $display("FAIL wr_clken%0d got %b want %b", k, clk_en, k == 3);
         end
         tick();
      end
      out_ready = '0;
      #1;
      checks++;
      if (out_valid !== 4'b0) begin
         errors++; $display("FAIL wr_done got %b want 0000", out_valid);
      end
      checks++;
      if (clk_en !== 1'b1) begin
         errors++; $display("FAIL wr_idle got %b want 1", clk_en);
      end
      tick();
   endtask

   task automatic test_same_channel;
      src = 3'd2;
      dst = 3'd2;
      in_valid = 4'b0100;
      in_data[2*W +: W] = 11'd13;
      dir_dst_data = 11'(-100);
      #1;
      checks++;
      if (in_ready !== 4'b0100 || dir_src_data !== 11'd13) begin
         errors++; $display("FAIL same_rd got %b/%0d want 0100/13", in_ready, dir_src_data);
      end
      checks++;
      if (clk_en !== 1'b0) begin
         errors++; $display("FAIL same_clken got %b want 0", clk_en);
      end
      tick();
      src = NONE;
      dst = NONE;
      in_valid = '0;
      in_data[2*W +: W] = 11'd99;
      out_ready = '1;
      #1;
      checks++;
      if (dir_src_data !== 11'd13) begin
         errors++; $display("FAIL same_hold got %0d want 13", dir_src_data);
      end
      checks++;
      if (out_valid !== 4'b0100 || od(2) !== 11'(-100)) begin
         errors++; $display("FAIL same_wr got %b/%0d want 0100/-100", out_valid, $signed(od(2)));
      end
      checks++;
      if (clk_en !== 1'b1 || in_ready !== 4'b0) begin
         errors++; $display("FAIL same_xfer got %b/%b want 1/0000", clk_en, in_ready);
      end
      tick();
      out_ready = '0;
      checks++;
      if (out_valid !== 4'b0 || od(2) !== 11'(-100)) begin
         errors++; $display("FAIL same_keep got %b/%0d want 0000/-100", out_valid, $signed(od(2)));
      end
   endtask

`ifdef DIR_ROUTER_ANY_LAST_EN
   task automatic test_any_last;
      src = ANY;
      dst = NONE;
      in_valid = 4'b1010;
      in_data[1*W +: W] = 11'd2;
      in_data[3*W +: W] = 11'd77;
      #1;
      checks++;
      if (in_ready !== 4'b0010 || dir_src_data !== 11'd2 || clk_en !== 1'b1) begin
         errors++; $display("FAIL any_rd got %b/%0d/%b want 0010/2/1", in_ready, dir_src_data, clk_en);
      end
      tick();
      src = LAST;
      in_valid = 4'b0010;
      in_data[1*W +: W] = 11'd9;
      #1;
      checks++;
      if (in_ready !== 4'b0010 || dir_src_data !== 11'd9) begin
         errors++; $display("FAIL last_rd got %b/%0d want 0010/9", in_ready, dir_src_data);
      end
      tick();
      src = NONE;
      dst = ANY;
      in_valid = '0;
      dir_dst_data = 11'd33;
      tick();
      dst = NONE;
      out_ready = 4'b1100;
      #1;
      checks++;
      if (out_valid !== 4'b1111 || clk_en !== 1'b1 || od(2) !== 11'd33) begin
         errors++; $display("FAIL any_wr got %b/%b/%0d want 1111/1/33", out_valid, clk_en, od(2));
      end
      tick();
      out_ready = '0;
      checks++;
      if (out_valid !== 4'b0) begin
         errors++; $display("FAIL any_done got %b want 0000", out_valid);
      end
      src = LAST;
      in_valid = 4'b0100;
      in_data[2*W +: W] = 11'd21;
      #1;
      checks++;
      if (in_ready !== 4'b0100 || dir_src_data !== 11'd21) begin
         errors++; $display("FAIL last_wr got %b/%0d want 0100/21", in_ready, dir_src_data);
      end
      tick();
      src = NONE;
      in_valid = '0;
   endtask
`else
   task automatic test_any_disabled;
      src = ANY;
      dst = NONE;
      in_valid = 4'b1111;
      in_data = {11'd4, 11'd3, 11'd2, 11'd1};
      #1;
      checks++;
      if (in_ready !== 4'b0 || dir_src_data !== 11'd0 || clk_en !== 1'b1) begin
         errors++; $display("FAIL nany_rd got %b/%0d/%b want 0000/0/1", in_ready, dir_src_data, clk_en);
      end
      tick();
      src = NONE;
      dst = ANY;
      in_valid = '0;
      dir_dst_data = 11'd5;
      #1;
      checks++;
      if (clk_en !== 1'b1) begin
         errors++; $display("FAIL nany_wr got %b want 1", clk_en);
      end
      tick();
      dst = NONE;
      checks++;
      if (out_valid !== 4'b0) begin
         errors++; $display("FAIL nany_ov got %b want 0000", out_valid);
      end
   endtask
`endif

   task automatic test_reset_in_write;
      src = NONE;
      dst = 3'd3;
      dir_dst_data = 11'd42;
      tick();
      dst = NONE;
      checks++;
      if (out_valid !== 4'b1000) begin
         errors++; $display("FAIL rw_pend got %b want 1000", out_valid);
      end
      reset = 1'b0;
      out_ready = '1;
      #1;
      checks++;
      if (clk_en !== 1'b0) begin
         errors++; $display("FAIL rw_clken got %b want 0", clk_en);
      end
      tick();
      reset = 1'b1;
      out_ready = '0;
      checks++;
      if (out_valid !== 4'b0 || od(3) !== 11'd0) begin
         errors++; $display("FAIL rw_drop got %b/%0d want 0000/0", out_valid, od(3));
      end
      src = LAST;
      in_valid = '1;
      in_data = {11'd8, 11'd7, 11'd6, 11'd5};
      #1;
      checks++;
      if (dir_src_data !== 11'd0 || clk_en !== 1'b1 || in_ready !== 4'b0) begin
         errors++; $display("FAIL rw_last got %0d/%b/%b want 0/1/0000", dir_src_data, clk_en, in_ready);
      end
      tick();
      src = NONE;
      in_valid = '0;
   endtask

   task automatic test_back_to_back;
      exp_t e;
      for (int n = 0; n < 24; n++) begin
         e.ch = int'($urandom_range(0, P - 1));
         e.d  = W'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            src = S'(e.ch);
            dst = NONE;
            in_valid = P'(1 << e.ch);
            in_data[e.ch*W +: W] = e.d;
            sb.push_back(e);
            #1;
            checks++;
            if (in_ready !== P'(1 << e.ch) || clk_en !== 1'b1) begin
               errors++; $display("FAIL b2b_rd%0d got %b/%b want %b/1", n, in_ready, clk_en, P'(1 << e.ch));
            end
            if (in_ready[e.ch]) begin
               e = sb.pop_front();
               checks++;
               if (dir_src_data !== e.d) begin
                  errors++; $display("FAIL b2b_rdata%0d got %0d want %0d", n, dir_src_data, e.d);
               end
            end
            tick();
            in_valid = '0;
            src = NONE;
            if (sb.size() != 0) void'(sb.pop_front());
         end else begin
            bit done;
            done = 1'b0;
            src = NONE;
            dst = S'(e.ch);
            dir_dst_data = e.d;
            sb.push_back(e);
            tick();
            dst = NONE;
            for (int t = 0; t < 20 && !done; t++) begin
               out_ready = (t >= 8) ? '1 : P'($urandom);
               #1;
               if (clk_en) begin
                  e = sb.pop_front();
                  done = 1'b1;
                  checks++;
                  if (out_valid !== P'(1 << e.ch) || od(e.ch) !== e.d) begin
                     errors++; $display("FAIL b2b_wr%0d got %b/%0d want %b/%0d", n, out_valid, od(e.ch), P'(1 << e.ch), e.d);
                  end
               end
               tick();
            end
            out_ready = '0;
            if (!done) begin
               checks++;
               errors++;
               $display("FAIL b2b_timeout%0d got no transfer want transfer", n);
               void'(sb.pop_front());
               reset = 1'b0;
               tick();
               reset = 1'b1;
            end
         end
      end
   endtask

   initial begin
      repeat (2) tick();
      reset = 1'b1;
      tick();
      test_reset();
      test_read();
      test_write();
      test_same_channel();
`ifdef DIR_ROUTER_ANY_LAST_EN
      test_any_last();
`else
      test_any_disabled();
`endif
      test_reset_in_write();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dir_router.md
DIR_ROUTER -- requirements
Module: dir_router

Interface
REQ-001 Parameter WIDTH, default 11: signed data word width.
REQ-002 Parameter PORTS, default 4: number of directional channels.
REQ-003 Parameter SEL_W, default 3: select code width; SHALL satisfy 2^SEL_W >= PORTS+3.
REQ-004 Select codes SHALL be: 0..PORTS-1 = channel index; PORTS = ANY; PORTS+1 = LAST; any other value = NONE (NIL or local register, no channel activity).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  reset, synchronous, active-low.
REQ-007 src  in  SEL_W  read select for the current instruction.
REQ-008 dst  in  SEL_W  write select for the current instruction.
REQ-009 in_data  in  PORTS*WIDTH  inbound words; channel i at bits [i*WIDTH +: WIDTH].
REQ-010 in_valid  in  PORTS  inbound valid per channel.
REQ-011 in_ready  out  PORTS  inbound ready per channel.
REQ-012 out_data  out  PORTS*WIDTH  outbound words, same packing as in_data.
REQ-013 out_valid  out  PORTS  outbound valid per channel.
REQ-014 out_ready  in  PORTS  outbound ready per channel.
REQ-015 clk_en  out  1  core advance enable; high = instruction completes this cycle.
REQ-016 dir_src_data  out  WIDTH  word read for the core.
REQ-017 dir_dst_data  in  WIDTH  word the core writes; may depend combinationally on dir_src_data.

Function
REQ-018 FSM states: IDLE, WRITE; a channel transfer occurs on a cycle where valid and ready are both high.
REQ-019 IDLE, src a channel: in_ready high only for that channel, combinationally, when its in_valid is high; otherwise no in_ready, clk_en low, remain IDLE.
REQ-020 IDLE, src ANY: lowest-index channel with in_valid high is selected; none valid = stall as REQ-019.
REQ-021 IDLE, src NONE: read satisfied immediately; dir_src_data = 0.
REQ-022 In IDLE, dir_src_data SHALL equal the selected channel's in_data combinationally.
REQ-023 IDLE, read satisfied, dst NONE: clk_en high same cycle; stay IDLE.
REQ-024 IDLE, read satisfied, dst channel/ANY/LAST: clk_en low; the read word is latched to a hold register; dir_dst_data is latched into the target channel's out_data register (all channels for ANY); next state WRITE.
REQ-025 WRITE: out_valid high on target channel(s); in_ready all low; dir_src_data = hold register; clk_en low until the write transfers.
REQ-026 WRITE transfer cycle: clk_en high; next cycle all out_valid low, state IDLE.
REQ-027 dst ANY: lowest-index channel with out_ready high takes the word; all other out_valid drop with it.
REQ-028 LAST register (index + valid flag): updated to the winning channel on an ANY read transfer or ANY write transfer; if both occur in one instruction, the write's channel wins.
REQ-029 src/dst LAST with LAST flag clear SHALL behave as NONE.
REQ-030 src and dst the same channel is legal: read first, then write.
REQ-031 out_data of idle channels SHALL hold last value; no combinational path from out_ready to out_data.

Reset
REQ-032 With reset low at a rising edge: state IDLE, all out_valid 0, all out_data 0, hold register 0, LAST flag 0.
REQ-033 While reset is low, clk_en 0 and all in_ready 0.
REQ-034 Reset during WRITE SHALL discard the pending word; out_valid low from the following cycle.

Configuration
REQ-035 Macro DIR_ROUTER_ANY_LAST_EN: when defined, ANY and LAST codes behave per REQ-020, REQ-027 to REQ-029.
REQ-036 Without DIR_ROUTER_ANY_LAST_EN: codes PORTS and PORTS+1 decode as NONE; no LAST register is implemented.

Verification
REQ-037 src=0, dst=NONE, in_valid[0]=1 with data 5 -> in_ready[0]=1, dir_src_data=5, clk_en=1 same cycle.
REQ-038 src=NONE, dst=1, dir_dst_data=-7, out_ready[1]=0 for 3 cycles then 1 -> out_valid[1]=1, out_data[1]=-7 for 4 cycles, clk_en=1 only on the 4th, out_valid low after.
REQ-039 src=ANY, in_valid=4'b1010 with data 2 on ch1 -> ch1 read, dir_src_data=2; next src=LAST, in_valid[1]=1 with data 9 -> ch1 read, dir_src_data=9.
REQ-040 dst=ANY, out_ready=4'b1100 -> ch2 accepts, out_valid all low next cycle; LAST = 2.
REQ-041 reset low while in WRITE -> out_valid 0, clk_en 0; after release, src=LAST reads as NONE (dir_src_data=0).
REQ-042 Without DIR_ROUTER_ANY_LAST_EN, src=ANY with in_valid=4'b1111 -> no in_ready, dir_src_data=0, clk_en=1.
